// File: rtl/cube_hub75_pkg.sv
// Shared types and defaults for the HUB75 scan controller and its output-enable timer.
package cube_hub75_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WAIT,
      ST_BLANK,
      ST_LATCH
   } scan_state_t;

   // Channel slots within a framebuffer word {r0,g0,b0,r1,g1,b1}, in units of BPC bits.
   localparam int CH_R0 = 5;
   localparam int CH_G0 = 4;
   localparam int CH_B0 = 3;
   localparam int CH_R1 = 2;
   localparam int CH_G1 = 1;
   localparam int CH_B1 = 0;

   localparam int DEF_COLS     = 32;
   localparam int DEF_ROW_BITS = 3;
   localparam int DEF_BPC      = 4;
   localparam int DEF_OE_UNIT  = 16;

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable display-window down-counter driving hub75_oe_ and an expiry flag.
// Optional brightness gating is built when CUBE_HUB75_BRIGHTNESS_EN is defined.
module hub75_oe_timer
   import cube_hub75_pkg::*;
#(
   parameter int OE_UNIT = DEF_OE_UNIT,
   parameter int TW      = 8
) (
   input  logic                     osc_clk,
   input  logic                     osc_reset,
   input  logic                     load,
   input  logic [TW-1:0]            load_val,
`ifdef CUBE_HUB75_BRIGHTNESS_EN
   input  logic [$clog2(OE_UNIT):0] brightness,
`endif
   output logic                     hub75_oe_,
   output logic                     expired
);

   logic [TW-1:0] cnt;
   logic [TW-1:0] cnt_nxt;
   logic          win_nxt;
   logic          lit_nxt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_nxt = cnt;
      win_nxt = 1'b0;
      if (load) begin
         cnt_nxt = load_val;
         win_nxt = 1'b1;
      end else if (cnt != '0) begin
         cnt_nxt = cnt - TW'(1);
         win_nxt = 1'b1;
      end
   end

`ifdef CUBE_HUB75_BRIGHTNESS_EN
   localparam int UB = $clog2(OE_UNIT);
   localparam logic [UB:0] UNIT_V = (UB+1)'(OE_UNIT);

   logic [UB:0]   br_q;
   logic [UB:0]   br_sel;
   logic [UB-1:0] k_mod;

   // Windows are whole multiples of OE_UNIT, so the window index mod OE_UNIT is ~count.
   always_comb begin
      br_sel  = load ? brightness : br_q;
      k_mod   = ~cnt_nxt[UB-1:0];
      lit_nxt = (br_sel >= UNIT_V) || ({1'b0, k_mod} < br_sel);
   end
`else
   assign lit_nxt = 1'b1;
`endif

   always_ff @(posedge osc_clk) begin
      if (osc_reset) begin
         cnt       <= '0;
         hub75_oe_ <= 1'b1;
`ifdef CUBE_HUB75_BRIGHTNESS_EN
         br_q      <= '0;
`endif
      end else begin
         cnt       <= cnt_nxt;
         hub75_oe_ <= !(win_nxt && lit_nxt);
`ifdef CUBE_HUB75_BRIGHTNESS_EN
         br_q      <= br_sel;
`endif
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: fetches, shifts and latches BCM planes row by row.
// Define CUBE_HUB75_BRIGHTNESS_EN to add the brightness input that gates the display window.
module hub75_scan_ctrl
   import cube_hub75_pkg::*;
#(
   parameter int COLS     = DEF_COLS,
   parameter int ROW_BITS = DEF_ROW_BITS,
   parameter int BPC      = DEF_BPC,
   parameter int OE_UNIT  = DEF_OE_UNIT
) (
   input  logic                     osc_clk,
   input  logic                     osc_reset,
   input  logic                     enable,
`ifdef CUBE_HUB75_BRIGHTNESS_EN
   input  logic [$clog2(OE_UNIT):0] brightness,
`endif
   output logic                     fb_rd_req,
   output logic [ROW_BITS-1:0]      fb_rd_row,
   output logic [$clog2(COLS)-1:0]  fb_rd_col,
   input  logic [6*BPC-1:0]         fb_rd_data,
   output logic                     hub75_clk,
   output logic                     hub75_lat,
   output logic                     hub75_oe_,
   output logic [ROW_BITS-1:0]      hub75_row,
   output logic                     hub75_r0,
   output logic                     hub75_g0,
   output logic                     hub75_b0,
   output logic                     hub75_r1,
   output logic                     hub75_g1,
   output logic                     hub75_b1,
   output logic                     frame_start
);

   localparam int CW = $clog2(COLS);
   localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TW = $clog2(OE_UNIT) + BPC;

   scan_state_t         state;
   logic                phase;
   logic [ROW_BITS-1:0] sh_row;
   logic [PW-1:0]       sh_plane;
   logic                load;
   logic [TW-1:0]       load_val;
   logic                expired;
   logic [BPC-1:0]      px_r0, px_g0, px_b0, px_r1, px_g1, px_b1;

   assign px_r0 = fb_rd_data[CH_R0*BPC +: BPC];
   assign px_g0 = fb_rd_data[CH_G0*BPC +: BPC];
   assign px_b0 = fb_rd_data[CH_B0*BPC +: BPC];
   assign px_r1 = fb_rd_data[CH_R1*BPC +: BPC];
   assign px_g1 = fb_rd_data[CH_G1*BPC +: BPC];
   assign px_b1 = fb_rd_data[CH_B1*BPC +: BPC];

   assign fb_rd_row = sh_row;

   // The plane just latched is displayed only if scanning continues; going idle leaves the panel dark.
   assign load     = (state == ST_LATCH) && enable;
   assign load_val = (TW'(OE_UNIT) << sh_plane) - TW'(1);

   hub75_oe_timer #(
      .OE_UNIT (OE_UNIT),
      .TW      (TW)
   ) u_oe_timer (
      .osc_clk    (osc_clk),
      .osc_reset  (osc_reset),
      .load       (load),
      .load_val   (load_val),
`ifdef CUBE_HUB75_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .hub75_oe_  (hub75_oe_),
      .expired    (expired)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge osc_clk) begin
      if (osc_reset) begin
         state       <= ST_IDLE;
         phase       <= 1'b0;
         sh_row      <= '0;
         sh_plane    <= '0;
         fb_rd_req   <= 1'b0;
         fb_rd_col   <= '0;
         hub75_clk   <= 1'b0;
         hub75_lat   <= 1'b0;
         hub75_row   <= '0;
         {hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1} <= '0;
         frame_start <= 1'b0;
      end else begin
         fb_rd_req   <= 1'b0;
         hub75_lat   <= 1'b0;
         frame_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state     <= ST_SHIFT;
                  fb_rd_req <= 1'b1;
                  fb_rd_col <= '0;
                  phase     <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // Phase 0 captures the word requested last cycle; phase 1 raises the panel clock.
               if (!phase) begin
                  hub75_r0  <= px_r0[sh_plane];
                  hub75_g0  <= px_g0[sh_plane];
                  hub75_b0  <= px_b0[sh_plane];
                  hub75_r1  <= px_r1[sh_plane];
                  hub75_g1  <= px_g1[sh_plane];
                  hub75_b1  <= px_b1[sh_plane];
                  hub75_clk <= 1'b0;
                  phase     <= 1'b1;
               end else begin
                  hub75_clk <= 1'b1;
                  phase     <= 1'b0;
                  if (fb_rd_col == CW'(COLS - 1)) begin
                     state <= ST_WAIT;
                  end else begin
                     fb_rd_req <= 1'b1;
                     fb_rd_col <= fb_rd_col + CW'(1);
                  end
               end
            end
            ST_WAIT: begin
               if (expired) state <= ST_BLANK;
            end
            ST_BLANK: begin
               state       <= ST_LATCH;
               hub75_lat   <= 1'b1;
               hub75_row   <= sh_row;
               frame_start <= (sh_row == '0) && (sh_plane == '0);
            end
            ST_LATCH: begin
               if (sh_plane == PW'(BPC - 1)) begin
                  sh_plane <= '0;
                  sh_row   <= sh_row + ROW_BITS'(1);
               end else begin
                  sh_plane <= sh_plane + PW'(1);
               end
               if (enable) begin
                  state     <= ST_SHIFT;
                  fb_rd_req <= 1'b1;
                  fb_rd_col <= '0;
                  phase     <= 1'b0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed self-checking bench for hub75_scan_ctrl (default parameters).
// Models brightness gating when CUBE_HUB75_BRIGHTNESS_EN is defined.
module tb_hub75_scan_ctrl;

   localparam int COLS     = 32;
   localparam int ROW_BITS = 3;
   localparam int BPC      = 4;
   localparam int OE_UNIT  = 16;
   localparam int BRIGHT   = 4;

   logic                osc_clk = 1'b0;
   logic                osc_reset;
   logic                enable;
   logic                fb_rd_req;
   logic [ROW_BITS-1:0] fb_rd_row;
   logic [4:0]          fb_rd_col;
   logic [6*BPC-1:0]    fb_rd_data = '0;
   logic                hub75_clk, hub75_lat, hub75_oe_;
   logic [ROW_BITS-1:0] hub75_row;
   logic                hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1;
   logic                frame_start;
`ifdef CUBE_HUB75_BRIGHTNESS_EN
   logic [4:0]          brightness;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   sh_row_m, sh_plane_m, disp_w, last_p0, last_fs;
   bit   track;
   logic exp_clk;
   logic [5:0] exp_rgb;

   hub75_scan_ctrl dut (
      .osc_clk     (osc_clk),
      .osc_reset   (osc_reset),
      .enable      (enable),
`ifdef CUBE_HUB75_BRIGHTNESS_EN
      .brightness  (brightness),
`endif
      .fb_rd_req   (fb_rd_req),
      .fb_rd_row   (fb_rd_row),
      .fb_rd_col   (fb_rd_col),
      .fb_rd_data  (fb_rd_data),
      .hub75_clk   (hub75_clk),
      .hub75_lat   (hub75_lat),
      .hub75_oe_   (hub75_oe_),
      .hub75_row   (hub75_row),
      .hub75_r0    (hub75_r0),
      .hub75_g0    (hub75_g0),
      .hub75_b0    (hub75_b0),
      .hub75_r1    (hub75_r1),
      .hub75_g1    (hub75_g1),
      .hub75_b1    (hub75_b1),
      .frame_start (frame_start)
   );

   always #5 osc_clk = ~osc_clk;

   function automatic logic [23:0] fb_pat(input int c);
      logic [3:0] v;
      v = 4'(c);
      return {v ^ 4'h5, 4'(c >> 1) ^ 4'hA, ~v, 4'(c * 3), 4'(c + 9), {v[0], v[3:1]}};
   endfunction

   function automatic logic [5:0] exp_rgb_f(input int c, input int p);
      logic [23:0] d;
      d = fb_pat(c);
      return {d[20+p], d[16+p], d[12+p], d[8+p], d[4+p], d[p]};
   endfunction

   function automatic bit lit(input int k);
`ifdef CUBE_HUB75_BRIGHTNESS_EN
      return (k % OE_UNIT) < ((BRIGHT < OE_UNIT) ? BRIGHT : OE_UNIT);
`else
      return (k >= 0);
`endif
   endfunction

   // Framebuffer read port: the word for a request is presented at the edge after it.
   always @(negedge osc_clk)
      fb_rd_data = fb_rd_req ? fb_pat(int'(fb_rd_col)) : ~fb_pat(int'(fb_rd_col));

   task automatic step();
      @(negedge osc_clk);
      cyc++;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rgb_obs();
      return int'({hub75_r0, hub75_g0, hub75_b0, hub75_r1, hub75_g1, hub75_b1});
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_clk"},   int'(hub75_clk),   0);
      check({tag, "_lat"},   int'(hub75_lat),   0);
      check({tag, "_oe_n"},  int'(hub75_oe_),   1);
      check({tag, "_row"},   int'(hub75_row),   0);
      check({tag, "_rgb"},   rgb_obs(),         0);
      check({tag, "_req"},   int'(fb_rd_req),   0);
      check({tag, "_frame"}, int'(frame_start), 0);
   endtask

   // Starts at the negedge of the LATCH (or enabling IDLE) cycle and ends at the next LATCH.
   task automatic run_period(input int drop_at);
      int   p_len, rises;
      logic prev_clk, exp_req, exp_oe;
      p_len    = ((2*COLS+1) > disp_w ? 2*COLS+1 : disp_w) + 2;
      rises    = 0;
      prev_clk = hub75_clk;
      for (int t = 1; t < p_len; t++) begin
         if (t == drop_at) enable = 1'b0;
         step();
         exp_req = (t < 2*COLS) && (t % 2 == 1);
         check("req", int'(fb_rd_req), int'(exp_req));
         if (exp_req) begin
            check("col", int'(fb_rd_col), (t - 1) / 2);
            check("fb_row", int'(fb_rd_row), sh_row_m);
         end
         if (t >= 2 && t <= 2*COLS+1) exp_clk = (t % 2 == 1);
         if (t >= 2 && t <= 2*COLS && t % 2 == 0) exp_rgb = exp_rgb_f((t - 2) / 2, sh_plane_m);
         check("clk", int'(hub75_clk), int'(exp_clk));
         check("rgb", rgb_obs(), int'(exp_rgb));
         exp_oe = !(t <= disp_w && lit(t - 1));
         check("oe_n", int'(hub75_oe_), int'(exp_oe));
         check("lat_low", int'(hub75_lat), 0);
         check("frame_low", int'(frame_start), 0);
         if (hub75_clk && !prev_clk) rises++;
         prev_clk = hub75_clk;
      end
      step();
      check("latch", int'(hub75_lat), 1);
      check("latch_row", int'(hub75_row), sh_row_m);
      check("latch_frame", int'(frame_start), int'(sh_row_m == 0 && sh_plane_m == 0));
      check("latch_oe_n", int'(hub75_oe_), 1);
      check("latch_req", int'(fb_rd_req), 0);
      check("rises", rises, COLS);
      if (track && sh_plane_m == 0) begin
         if (last_p0 >= 0) check("row_period", cyc - last_p0, 331);
         last_p0 = cyc;
      end
      if (track && sh_plane_m == 0 && sh_row_m == 0) begin
         if (last_fs >= 0) check("frame_period", cyc - last_fs, 2648);
         last_fs = cyc;
      end
      disp_w = enable ? (OE_UNIT << sh_plane_m) : 0;
      if (sh_plane_m == BPC - 1) begin
         sh_plane_m = 0;
         sh_row_m   = (sh_row_m + 1) % (1 << ROW_BITS);
      end else begin
         sh_plane_m++;
      end
   endtask

   initial begin
      osc_reset  = 1'b1;
      enable     = 1'b1;
`ifdef CUBE_HUB75_BRIGHTNESS_EN
      brightness = 5'(BRIGHT);
`endif
      sh_row_m   = 0;
      sh_plane_m = 0;
      disp_w     = 0;
      last_p0    = -1;
      last_fs    = -1;
      track      = 1'b1;
      exp_clk    = 1'b0;
      exp_rgb    = '0;

      // Reset held with enable high: everything at reset values.
      repeat (3) step();
      check_reset_vals("rst");

      // First period starts straight from IDLE with no display, then one full frame free-running.
      osc_reset = 1'b0;
      run_period(-1);
      for (int i = 0; i < 32; i++) run_period(-1);

      // Drop enable mid-shift of plane 2: it still latches, then the block stays dark and idle.
      track = 1'b0;
      run_period(-1);
      run_period(10);
      for (int i = 0; i < 150; i++) begin
         step();
         check("idle_oe_n", int'(hub75_oe_), 1);
         check("idle_req", int'(fb_rd_req), 0);
         check("idle_lat", int'(hub75_lat), 0);
         check("idle_clk", int'(hub75_clk), int'(exp_clk));
         check("idle_rgb", rgb_obs(), int'(exp_rgb));
      end

      // Resume: plane 3 of row 0 shifts without display, then plane 3 displays for 128 cycles.
      enable = 1'b1;
      run_period(-1);
      run_period(-1);

      // Reset mid-shift aborts to reset values; scanning restarts at row 0, plane 0.
      repeat (20) step();
      osc_reset = 1'b1;
      step();
      check_reset_vals("midrst");
      step();
      check_reset_vals("midrst2");
      osc_reset  = 1'b0;
      sh_row_m   = 0;
      sh_plane_m = 0;
      disp_w     = 0;
      exp_clk    = 1'b0;
      exp_rgb    = '0;
      run_period(-1);
      run_period(-1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
